// File: rtl/name_feed_arbiter_if.sv
// name_feed_arbiter_if: bundles the two requester handshakes and the pipeline
// lane of name_feed_arbiter. The master modport is the environment side
// (requesters plus pipeline). The slave modport is the arbiter itself.
interface name_feed_arbiter_if #(
  parameter int WORD_SIZE       = 32,
  parameter int COMP_INDEX_SIZE = 3
);
  logic                       req0_valid;
  logic [WORD_SIZE-1:0]       req0_word;
  logic                       req0_last;
  logic                       req0_ready;
  logic                       req1_valid;
  logic [WORD_SIZE-1:0]       req1_word;
  logic                       req1_last;
  logic                       req1_ready;
  logic                       pipe_stall;
  logic                       pipe_valid;
  logic [WORD_SIZE-1:0]       pipe_word;
  logic [COMP_INDEX_SIZE-1:0] pipe_comp_index;
  logic                       pipe_first;
  logic                       pipe_last;
  logic                       pipe_src;
  logic                       busy;

  modport master (
    output req0_valid, req0_word, req0_last,
    input  req0_ready,
    output req1_valid, req1_word, req1_last,
    input  req1_ready,
    output pipe_stall,
    input  pipe_valid, pipe_word, pipe_comp_index, pipe_first, pipe_last,
    input  pipe_src, busy
  );

  modport slave (
    input  req0_valid, req0_word, req0_last,
    output req0_ready,
    input  req1_valid, req1_word, req1_last,
    output req1_ready,
    input  pipe_stall,
    output pipe_valid, pipe_word, pipe_comp_index, pipe_first, pipe_last,
    output pipe_src, busy
  );
endinterface

// File: rtl/name_feed_arbiter.sv
// name_feed_arbiter: grants one whole name at a time from two requesters
// (round-robin) and serialises its components onto a single pipeline lane.
// Each component is held for HOLD_CYCLES non-stalled clocks and is tagged with
// its index, first/last flags and source id. Names longer than MAX_NAME_LENGTH
// are cut short, and the excess components are drained and discarded.
// Optional statistics counters: define NAME_FEED_STATS_EN.
module name_feed_arbiter #(
  parameter int WORD_SIZE       = 32,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int COMP_INDEX_SIZE = 3,
  parameter int HOLD_CYCLES     = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  name_feed_arbiter_if.slave bus
`ifdef NAME_FEED_STATS_EN
  ,
  output logic [15:0] stat_names_out,
  output logic [15:0] stat_trunc_out,
  output logic [15:0] stat_stall_out
`endif
);
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [COMP_INDEX_SIZE-1:0] IDX_LAST = COMP_INDEX_SIZE'(MAX_NAME_LENGTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DRAIN} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [HC_W-1:0]            r_hold_cnt;
  logic                       r_ptr;     // requester that wins the next tie
  logic                       r_src;     // requester owning the current name
  logic                       r_first;
  logic                       r_last;
  logic                       r_trunc;   // last flag was forced by the length limit
  logic [COMP_INDEX_SIZE-1:0] r_idx;
  logic [WORD_SIZE-1:0]       r_word;

  logic                       w_gnt;
  logic                       w_sel;
  logic                       w_sel_valid;
  logic                       w_sel_last;
  logic [WORD_SIZE-1:0]       w_sel_word;
  logic                       w_rdy;
  logic                       w_load;
  logic                       w_hold_done;
  logic [COMP_INDEX_SIZE-1:0] w_idx_nxt;
  logic                       w_at_limit;

  // A single valid requester wins outright. On a tie, the pointer decides.
  assign w_gnt       = (bus.req0_valid && bus.req1_valid) ? r_ptr : bus.req1_valid;
  // Between names the arbitration winner is selected. Inside a name it is the owner.
  assign w_sel       = (r_state == S_IDLE) ? w_gnt : r_src;
  assign w_sel_valid = w_sel ? bus.req1_valid : bus.req0_valid;
  assign w_sel_last  = w_sel ? bus.req1_last  : bus.req0_last;
  assign w_sel_word  = w_sel ? bus.req1_word  : bus.req0_word;
  assign w_idx_nxt   = (r_state == S_IDLE) ? '0 : r_idx + 1'b1;
  assign w_at_limit  = (w_idx_nxt == IDX_LAST);

  // Next-state, ready and load decisions
  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_load      = 1'b0;
    w_hold_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!bus.pipe_stall && w_sel_valid) begin
          w_rdy       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.pipe_stall && (r_hold_cnt == HOLD_LAST)) begin
          w_hold_done = 1'b1;
          if (r_last) begin
            w_state_nxt = r_trunc ? S_DRAIN : S_IDLE;
          end else begin
            w_rdy = 1'b1;
            if (w_sel_valid) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        w_rdy = !bus.pipe_stall;
        if (!bus.pipe_stall && w_sel_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_DRAIN: begin
        // Surplus components are swallowed up to and including the requester's last.
        w_rdy = 1'b1;
        if (w_sel_valid && w_sel_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, hold counter, component tags and round-robin pointer
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_ptr      <= 1'b0;
      r_src      <= 1'b0;
      r_idx      <= '0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_trunc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_hold_cnt <= '0;
        r_idx      <= w_idx_nxt;
        r_first    <= (r_state == S_IDLE);
        r_last     <= w_sel_last || w_at_limit;
        r_trunc    <= !w_sel_last && w_at_limit;
      end else if ((r_state == S_SEND) && !bus.pipe_stall) begin
        r_hold_cnt <= w_hold_done ? '0 : r_hold_cnt + 1'b1;
      end
      if ((r_state == S_IDLE) && w_load) begin
        r_src <= w_gnt;
        r_ptr <= !w_gnt;
      end
    end
  end

  // Component data register, written only when a component is accepted
  always_ff @(posedge clk_in) begin
    if (w_load) begin
      r_word <= w_sel_word;
    end
  end

  assign bus.req0_ready      = w_rdy && !w_sel;
  assign bus.req1_ready      = w_rdy &&  w_sel;
  assign bus.pipe_valid      = (r_state == S_SEND);
  assign bus.pipe_word       = bus.pipe_valid ? r_word : '0;
  assign bus.pipe_comp_index = r_idx;
  assign bus.pipe_first      = bus.pipe_valid && r_first;
  assign bus.pipe_last       = bus.pipe_valid && r_last;
  assign bus.pipe_src        = r_src;
  assign bus.busy            = (r_state != S_IDLE);

`ifdef NAME_FEED_STATS_EN
  logic [15:0] r_stat_names;
  logic [15:0] r_stat_trunc;
  logic [15:0] r_stat_stall;

  // Wrapping event counters: completed names, truncated names, stalled output cycles
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_stat_names <= '0;
      r_stat_trunc <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_hold_done && r_last) begin
        r_stat_names <= r_stat_names + 1'b1;
      end
      if (w_hold_done && r_last && r_trunc) begin
        r_stat_trunc <= r_stat_trunc + 1'b1;
      end
      if (bus.pipe_valid && bus.pipe_stall) begin
        r_stat_stall <= r_stat_stall + 1'b1;
      end
    end
  end

  assign stat_names_out = r_stat_names;
  assign stat_trunc_out = r_stat_trunc;
  assign stat_stall_out = r_stat_stall;
`endif

endmodule

// File: doc/name_feed_arbiter.md
Name: name_feed_arbiter

Overview:
- Sits in front of the FIB lookup pipeline input (`top` name_component port).
- Two name sources (requesters) each supply a name as a stream of 32-bit components. The block grants one whole name at a time, round-robin, and serialises its components onto one pipeline lane.
- Each component is held for HOLD_CYCLES clocks, tagged with component index, first/last flags and source id.
- Replaces ad-hoc name/component counters used to flatten names into the pipeline.

Parameters:
- WORD_SIZE, 32, width of one name component.
- MAX_NAME_LENGTH, 8, maximum components per name forwarded to the pipeline.
- COMP_INDEX_SIZE, 3, width of component index; 2^COMP_INDEX_SIZE >= MAX_NAME_LENGTH.
- HOLD_CYCLES, 2, clocks each component stays on the output; legal range >= 1.

Ports:
- clk_in  in  1  single clock, rising edge.
- rst_in  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 component valid.
- req0_word  in  WORD_SIZE  requester 0 component.
- req0_last  in  1  marks final component of requester 0 name.
- req0_ready  out  1  component accepted when req0_valid && req0_ready.
- req1_valid, req1_word, req1_last, req1_ready  same as requester 0, for requester 1.
- pipe_stall  in  1  pipeline backpressure; freezes output and hold count.
- pipe_valid  out  1  pipe_word is valid.
- pipe_word  out  WORD_SIZE  component to the pipeline.
- pipe_comp_index  out  COMP_INDEX_SIZE  position of the component in its name, starting at 0.
- pipe_first  out  1  high while component index 0 is presented.
- pipe_last  out  1  high while the final forwarded component is presented.
- pipe_src  out  1  source of the current name (0 or 1).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, hold_cnt 0, round-robin pointer 0 (requester 0 wins the first tie). Reset mid-name abandons the name; nothing resumes after reset.
- States: IDLE, SEND, WAIT, DRAIN.
- IDLE, arbitration:
  - Only one requester valid: it wins.
  - Both valid: the requester not granted last wins.
  - Winner's ready is asserted combinationally when pipe_stall = 0. The first word is captured on that edge; next cycle pipe_valid = 1, comp_index 0, pipe_first = 1. Go to SEND.
  - Grant and pipe_src are latched for the whole name. The pointer updates on grant.
- SEND, hold:
  - Each word is presented for HOLD_CYCLES non-stalled cycles.
  - pipe_stall = 1 freezes all outputs and hold_cnt. Ready is low during stall.
- SEND, hand-over:
  - In the final hold cycle with no stall and the current word not last, granted ready = 1.
  - If valid, the next word is loaded back-to-back and comp_index increments.
  - If not valid (underrun), go to WAIT.
- WAIT:
  - pipe_valid = 0; ready stays high (when not stalled).
  - When the word arrives, load it and return to SEND; comp_index continues.
- Name end:
  - A word captured with req_last = 1 gets pipe_last = 1.
  - After its final hold cycle, go to IDLE; pipe_valid = 0 for exactly one bubble cycle before the next name.
- Truncation:
  - A word captured at comp_index = MAX_NAME_LENGTH-1 with req_last = 0 is forced pipe_last = 1.
  - After its hold, go to DRAIN. In DRAIN, ready = 1 for the granted requester and words are discarded (pipe_valid = 0) up to and including req_last, then IDLE.
- The non-granted requester's ready is always 0.
- HOLD_CYCLES = 1: one word per clock, no repeats.

Optional Feature:
- Macro: NAME_FEED_STATS_EN.
- Defined: adds these ports, all reset to 0 and wrapping on overflow:
  - stat_names_out [15:0]: increments on each pipe_last hold completion.
  - stat_trunc_out [15:0]: increments per truncated name.
  - stat_stall_out [15:0]: counts cycles with pipe_valid && pipe_stall.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single name, HOLD=2: req0 sends 0xA0,0xA1,0xA2 (last on 0xA2) right after reset.
  - Expect pipe_word 0xA0 for 2 cycles, then 0xA1 for 2, then 0xA2 for 2; comp_index 0,1,2.
  - pipe_first only on 0xA0, pipe_last only on 0xA2, pipe_src = 0, then one cycle pipe_valid = 0.
- Tie arbitration: both requesters hold 2-word names after reset.
  - Expect req0 name, bubble, req1 name, bubble.
  - A second tie grants req0 again; req1_ready stays 0 throughout req0's name.
- Truncation: req1 sends 10 words 0x10..0x19, last on 0x19.
  - Expect 0x10..0x17 forwarded with pipe_last on comp_index 7.
  - 0x18 and 0x19 accepted (ready = 1) but never on pipe_word; IDLE afterwards.
- Stall: pipe_stall = 1 for 3 cycles during the first hold cycle of word 0xA1.
  - Expect 0xA1 visible for 2+3 = 5 cycles and req0_ready low during the stall.
- Underrun: req0_valid drops for 4 cycles between 0xA1 and 0xA2.
  - Expect pipe_valid = 0 for those cycles; 0xA2 then appears with comp_index 2 and src unchanged.
- Reset mid-name: rst_in = 1 during word 1 of a 4-word name.
  - Expect all outputs 0 next cycle, busy = 0.
  - A new req1 request after reset is granted immediately with comp_index 0.
